uart_rx_byte: RTL and testbench
===============================

UART_RX_BYTE -- requirements
Module: uart_rx_byte

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 16, clk cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data bits per frame.
REQ-003 SHALL have port clk, input, 1, the only clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line; idle high.
REQ-006 SHALL have port rx_data, output, DATA_WIDTH, the received byte; held stable while rx_rdy=1.
REQ-007 SHALL have port rx_rdy, output, 1, rx_data valid; a registered output.
REQ-008 SHALL have port rx_ack, input, 1, consumer has taken rx_data; may be combinational from rx_rdy.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit samples 0.
REQ-010 SHALL have port overrun, output, 1, one-cycle pulse when a received byte is dropped.

Function
REQ-011 SHALL pass rx through a two-flop synchronizer; all line decisions use the synchronized value.
REQ-012 SHALL implement the FSM states IDLE, START, DATA, STOP (plus PARITY, see Configuration).
REQ-013 SHALL move from IDLE to START on the first cycle the synchronized rx is 0, and load the bit counter with BAUD_DIV/2-1.
REQ-014 SHALL, in START, resample rx when the counter reaches 0: rx=0 -> DATA with counter BAUD_DIV-1; rx=1 -> IDLE (glitch rejected, no output activity).
REQ-015 SHALL, in DATA, sample one bit each time the counter reaches 0, LSB first, and reload the counter with BAUD_DIV-1; after DATA_WIDTH bits it moves to STOP.
REQ-016 SHALL, in STOP at counter 0, act on the sampled bit: 1 -> frame accepted; 0 -> frame_err=1 for one cycle and the byte discarded; both cases return to IDLE.
REQ-017 SHALL, on an accepted frame, load rx_data and set rx_rdy=1 on the next clk edge.
REQ-018 SHALL clear rx_rdy on the edge where rx_ack=1 is sampled with rx_rdy=1; rx_ack is ignored while rx_rdy=0.
REQ-019 SHALL, on an accepted frame while rx_rdy=1 and rx_ack=0, keep the old rx_data, keep rx_rdy=1, and pulse overrun for one cycle.
REQ-020 SHALL, on an accepted frame in the same cycle as rx_ack=1, load the new byte and keep rx_rdy=1 with no overrun.
REQ-021 SHALL keep the receive FSM independent of rx_rdy; reception continues while output is pending.
REQ-022 SHALL size the counter as $clog2(BAUD_DIV) bits; the counter never wraps past its reload value.
REQ-023 SHALL give a latency of 2 sync cycles + (DATA_WIDTH+1.5)*BAUD_DIV ±1 cycles from the start-bit falling edge to rx_rdy.

Reset
REQ-024 SHALL, on rst=0, immediately force the FSM to IDLE, the counter to 0, rx_data to 0, rx_rdy to 0, frame_err to 0, overrun to 0, and the synchronizer flops to 1.
REQ-025 SHALL discard any partial frame when reset is asserted mid-frame; after release it waits for a fresh falling edge.

Configuration
REQ-026 SHALL, with UART_RX_PARITY_EN defined, insert a PARITY state between DATA and STOP that samples one even-parity bit; on mismatch frame_err pulses, the byte is discarded, and the FSM still passes through STOP timing before IDLE.
REQ-027 SHALL, without UART_RX_PARITY_EN, omit the PARITY state and its logic entirely; the frame is start + DATA_WIDTH + stop.

Structure
REQ-028 SHALL place the FSM state encoding and the frame-length constants in shared package uart_pkg.
REQ-029 SHALL implement the synchronizer as sub-module sync_2ff (1-bit, asynchronous active-low reset, configurable reset value).

Verification (BAUD_DIV=16, DATA_WIDTH=8)
REQ-030 SHALL cover a single byte: send frame 0xA5 with rx_ack tied to rx_rdy -> rx_data=0xA5, one-cycle rx_rdy pulse, no frame_err or overrun.
REQ-031 SHALL cover a glitch: drive rx low for 4 cycles, then high -> FSM returns to IDLE, rx_rdy and frame_err stay 0.
REQ-032 SHALL cover a frame error: send 0x3C with stop bit 0 -> frame_err pulse, rx_rdy stays 0, and the next valid 0x55 is received correctly.
REQ-033 SHALL cover overrun: send 0x11 then 0x22 with rx_ack=0 -> overrun pulse, rx_data stays 0x11; then rx_ack=1 for 1 cycle -> rx_rdy=0.
REQ-034 SHALL cover reset mid-frame: assert rst during bit 3 of 0xF0, then send 0x0F -> only 0x0F is delivered.
REQ-035 SHALL cover parity with UART_RX_PARITY_EN defined: 0x07 with parity 1 is accepted; 0x07 with parity 0 gives frame_err and no rx_rdy.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- shared definitions for the UART byte receiver.
//
// Contents:
//   rx_state_e    : receive FSM state encoding
//   START_BITS    : start bits per frame
//   STOP_BITS     : stop bits per frame
//   PARITY_BITS   : parity bits per frame (1 when UART_RX_PARITY_EN is defined)
//   frame_bits()  : total serial bits in one frame for a given data width
//
// Build option: define UART_RX_PARITY_EN to add one even-parity bit between the
// data bits and the stop bit.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } rx_state_e;

    localparam int START_BITS = 1;
    localparam int STOP_BITS  = 1;
`ifdef UART_RX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_bits(input int data_width);
        return START_BITS + data_width + PARITY_BITS + STOP_BITS;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff -- two-flop synchronizer for a single asynchronous bit.
//
// Parameters:
//   RESET_VAL : value both flops take while rst_n is low
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte -- UART receiver delivering one DATA_WIDTH-bit word per frame.
//
// Parameters:
//   BAUD_DIV   : clk cycles per serial bit (4..65535)
//   DATA_WIDTH : data bits per frame, sent LSB first
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   rx        : asynchronous serial line, idle high
//   rx_data   : last accepted word, stable while rx_rdy is high
//   rx_rdy    : rx_data valid (registered)
//   rx_ack    : consumer has taken rx_data; only honoured while rx_rdy is high
//   frame_err : one-cycle pulse when a frame is rejected (bad stop/parity)
//   overrun   : one-cycle pulse when an accepted word is dropped because the
//               previous one was still pending
//
// Build option: UART_RX_PARITY_EN adds an even-parity bit after the data bits.
// -----------------------------------------------------------------------------
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_rdy,
    input  logic                  rx_ack,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_WIDTH - 1);

    logic rx_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (rx),
        .q     (rx_s)
    );

    rx_state_e              state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0]  shift_q,   shift_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_err_q, par_err_d;
`endif

    logic [DATA_WIDTH-1:0]  rx_data_q,   rx_data_d;
    logic                   rx_rdy_q,    rx_rdy_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q,   overrun_d;

    // Single-cycle strobes from the FSM at the stop-bit sample point.
    logic frame_ok;
    logic frame_bad;
    logic cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // ---------------------------------------------------------------------
    // Receive FSM: runs regardless of rx_rdy, so a pending word never stalls
    // the line.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        frame_ok  = 1'b0;
        frame_bad = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    // Half a bit to reach the middle of the start bit.
                    state_d = ST_START;
                    cnt_d   = HALF_RELOAD;
                end
            end

            ST_START: begin
                if (cnt_zero) begin
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        cnt_d     = FULL_RELOAD;
                        bit_idx_d = '0;
                    end else begin
                        // Line bounced back high: treat as noise.
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (cnt_zero) begin
                    // LSB arrives first, so shift in from the top.
                    shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    cnt_d   = FULL_RELOAD;
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_zero) begin
                    // Even parity: data bits plus parity bit must XOR to 0.
                    // The verdict is held until the stop bit so the frame
                    // timing is identical whether or not parity fails.
                    par_err_d = (^shift_q) ^ rx_s;
                    cnt_d     = FULL_RELOAD;
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif

            ST_STOP: begin
                if (cnt_zero) begin
`ifdef UART_RX_PARITY_EN
                    if (rx_s && !par_err_q) begin
`else
                    if (rx_s) begin
`endif
                        frame_ok = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Output holding register and handshake.
    // ---------------------------------------------------------------------
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_rdy_d    = rx_rdy_q;
        frame_err_d = frame_bad;
        overrun_d   = 1'b0;

        if (frame_ok) begin
            if (!rx_rdy_q || rx_ack) begin
                // Slot free, or being freed this very cycle: take new word.
                rx_data_d = shift_q;
                rx_rdy_d  = 1'b1;
            end else begin
                // Consumer still holds the previous word; drop the new one.
                overrun_d = 1'b1;
            end
        end else if (rx_rdy_q && rx_ack) begin
            rx_rdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            rx_data_q   <= '0;
            rx_rdy_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
            rx_data_q   <= rx_data_d;
            rx_rdy_q    <= rx_rdy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_rdy    = rx_rdy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_byte -- directed self-checking bench for uart_rx_byte
// (BAUD_DIV=16, DATA_WIDTH=8). Define UART_RX_PARITY_EN to also run the
// parity scenario against a parity-enabled build.
// -----------------------------------------------------------------------------
module tb_uart_rx_byte;
    import uart_pkg::*;

    localparam int BAUD  = 16;
    localparam int DW    = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Cycles from driving the start bit low to the accepting clock edge:
    // 2 sync + 1 idle detect + 8 half-bit + DW*16 + 16 (+16 with parity).
    localparam int ACCEPT_EDGE = 155 + BAUD * (NBITS - 10);

    logic          clk;
    logic          rst;
    logic          rx;
    logic [DW-1:0] rx_data;
    logic          rx_rdy;
    logic          rx_ack;
    logic          frame_err;
    logic          overrun;

    logic          ack_tie;
    logic          ack_reg;

    int checks;
    int errors;

    int cyc;
    int start_cyc;
    int rise_cyc;
    int rdy_rises;
    int ferr_cycles;
    int ovr_cycles;
    logic          rdy_prev;
    logic [DW-1:0] rise_data;

    assign rx_ack = ack_tie ? rx_rdy : ack_reg;

    uart_rx_byte #(
        .BAUD_DIV   (BAUD),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: counts output events on the falling edge.
    always @(negedge clk) begin
        if (rx_rdy && !rdy_prev) begin
            rdy_rises <= rdy_rises + 1;
            rise_cyc  <= cyc;
            rise_data <= rx_data;
        end
        if (frame_err) ferr_cycles <= ferr_cycles + 1;
        if (overrun)   ovr_cycles  <= ovr_cycles + 1;
        rdy_prev <= rx_rdy;
    end

    function automatic logic [15:0] make_frame(input logic [7:0] d, input logic par,
                                               input logic stop);
        logic [15:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_RX_PARITY_EN
        f[9]   = par;
        f[10]  = stop;
`else
        f[9]   = stop;
        f[15]  = par | 1'b1;   // beyond the frame: line stays idle high
`endif
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame bit-by-bit; ack_reg pulses during iteration ack_cycle
    // (negative = never), so it is sampled on edge ack_cycle+1 from start.
    task automatic send_frame(input logic [15:0] bits, input int ack_cycle);
        start_cyc = cyc;
        for (int c = 0; c < NBITS * BAUD; c++) begin
            rx      = bits[c / BAUD];
            ack_reg = (c == ack_cycle);
            tick(1);
        end
        rx      = 1'b1;
        ack_reg = 1'b0;
        tick(24);
    endtask

    task automatic ack_pulse();
        ack_reg = 1'b1;
        tick(1);
        ack_reg = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx  = 1'b1;
        tick(3);
        checks++;
        if (rx_rdy !== 1'b0) begin
            errors++; $display("FAIL reset_rdy: got %b want 0", rx_rdy);
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h want 00", rx_data);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_ferr: got %b want 0", frame_err);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL reset_ovr: got %b want 0", overrun);
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_IDLE);
        end
        rst = 1'b1;
        tick(4);
        $display("test_reset done: rdy=%b data=%h", rx_rdy, rx_data);
    endtask

    task automatic test_single_byte();
        int r0, f0, o0, hi;
        ack_tie = 1'b1;
        r0 = rdy_rises; f0 = ferr_cycles; o0 = ovr_cycles;
        hi = 0;
        fork
            send_frame(make_frame(8'hA5, ^8'hA5, 1'b1), -1);
            begin
                // Count high cycles of rx_rdy over the frame window.
                repeat ((NBITS + 1) * BAUD + 24) begin
                    @(negedge clk);
                    if (rx_rdy) hi++;
                end
            end
        join
        checks++;
        if (rdy_rises - r0 != 1) begin
            errors++; $display("FAIL single_count: got %0d want 1", rdy_rises - r0);
        end
        checks++;
        if (rise_data !== 8'hA5) begin
            errors++; $display("FAIL single_data: got %h want a5", rise_data);
        end
        checks++;
        if (hi != 1) begin
            errors++; $display("FAIL single_pulse: got %0d cycles want 1", hi);
        end
        checks++;
        if (ferr_cycles != f0 || ovr_cycles != o0) begin
            errors++; $display("FAIL single_flags: got ferr=%0d ovr=%0d want 0 0",
                               ferr_cycles - f0, ovr_cycles - o0);
        end
        checks++;
        if (rise_cyc - start_cyc < ACCEPT_EDGE - 1 || rise_cyc - start_cyc > ACCEPT_EDGE + 1) begin
            errors++; $display("FAIL single_latency: got %0d want %0d+-1",
                               rise_cyc - start_cyc, ACCEPT_EDGE);
        end
        $display("test_single_byte: data=%h latency=%0d", rise_data, rise_cyc - start_cyc);
    endtask

    task automatic test_glitch();
        int r0, f0;
        ack_tie = 1'b1;
        r0 = rdy_rises; f0 = ferr_cycles;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++; $display("FAIL glitch_state: got %0d want %0d", dut.state_q, ST_IDLE);
        end
        checks++;
        if (rdy_rises != r0) begin
            errors++; $display("FAIL glitch_rdy: got %0d rises want 0", rdy_rises - r0);
        end
        checks++;
        if (ferr_cycles != f0) begin
            errors++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cycles - f0);
        end
        $display("test_glitch: state=%0d rdy=%b", dut.state_q, rx_rdy);
    endtask

    task automatic test_frame_err();
        int r0, f0;
        ack_tie = 1'b1;
        r0 = rdy_rises; f0 = ferr_cycles;
        send_frame(make_frame(8'h3C, ^8'h3C, 1'b0), -1);
        checks++;
        if (ferr_cycles - f0 != 1) begin
            errors++; $display("FAIL ferr_pulse: got %0d cycles want 1", ferr_cycles - f0);
        end
        checks++;
        if (rdy_rises != r0) begin
            errors++; $display("FAIL ferr_rdy: got %0d rises want 0", rdy_rises - r0);
        end
        send_frame(make_frame(8'h55, ^8'h55, 1'b1), -1);
        checks++;
        if (rdy_rises - r0 != 1) begin
            errors++; $display("FAIL ferr_next_count: got %0d want 1", rdy_rises - r0);
        end
        checks++;
        if (rise_data !== 8'h55) begin
            errors++; $display("FAIL ferr_next_data: got %h want 55", rise_data);
        end
        $display("test_frame_err: ferr=%0d next=%h", ferr_cycles - f0, rise_data);
    endtask

    task automatic test_overrun();
        int o0;
        ack_tie = 1'b0;
        ack_reg = 1'b0;
        o0 = ovr_cycles;
        send_frame(make_frame(8'h11, ^8'h11, 1'b1), -1);
        send_frame(make_frame(8'h22, ^8'h22, 1'b1), -1);
        checks++;
        if (ovr_cycles - o0 != 1) begin
            errors++; $display("FAIL ovr_pulse: got %0d cycles want 1", ovr_cycles - o0);
        end
        checks++;
        if (rx_data !== 8'h11) begin
            errors++; $display("FAIL ovr_data: got %h want 11", rx_data);
        end
        checks++;
        if (rx_rdy !== 1'b1) begin
            errors++; $display("FAIL ovr_rdy_held: got %b want 1", rx_rdy);
        end
        ack_pulse();
        checks++;
        if (rx_rdy !== 1'b0) begin
            errors++; $display("FAIL ovr_ack_clear: got %b want 0", rx_rdy);
        end
        $display("test_overrun: ovr=%0d data=%h rdy_after_ack=%b", ovr_cycles - o0, rx_data, rx_rdy);
    endtask

    task automatic test_ack_same_cycle();
        int o0;
        ack_tie = 1'b0;
        send_frame(make_frame(8'h33, ^8'h33, 1'b1), -1);
        o0 = ovr_cycles;
        // Acknowledge 0x33 exactly on the edge that accepts 0x44.
        send_frame(make_frame(8'h44, ^8'h44, 1'b1), ACCEPT_EDGE - 1);
        checks++;
        if (rx_data !== 8'h44) begin
            errors++; $display("FAIL same_data: got %h want 44", rx_data);
        end
        checks++;
        if (rx_rdy !== 1'b1) begin
            errors++; $display("FAIL same_rdy: got %b want 1", rx_rdy);
        end
        checks++;
        if (ovr_cycles != o0) begin
            errors++; $display("FAIL same_ovr: got %0d want 0", ovr_cycles - o0);
        end
        ack_pulse();
        $display("test_ack_same_cycle: data=%h rdy=%b", rx_data, rx_rdy);
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] bits;
        int r0;
        ack_tie = 1'b1;
        bits = make_frame(8'hF0, ^8'hF0, 1'b1);
        // Start bit, bits 0..2, then halfway into bit 3.
        for (int c = 0; c < 4 * BAUD + 8; c++) begin
            rx = bits[c / BAUD];
            tick(1);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++; $display("FAIL midrst_state: got %0d want %0d", dut.state_q, ST_IDLE);
        end
        rx = 1'b1;
        tick(3);
        rst = 1'b1;
        r0 = rdy_rises;
        tick(200);
        checks++;
        if (rdy_rises != r0) begin
            errors++; $display("FAIL midrst_partial: got %0d rises want 0", rdy_rises - r0);
        end
        send_frame(make_frame(8'h0F, ^8'h0F, 1'b1), -1);
        checks++;
        if (rdy_rises - r0 != 1) begin
            errors++; $display("FAIL midrst_count: got %0d want 1", rdy_rises - r0);
        end
        checks++;
        if (rise_data !== 8'h0F) begin
            errors++; $display("FAIL midrst_data: got %h want 0f", rise_data);
        end
        $display("test_reset_mid_frame: delivered=%0d data=%h", rdy_rises - r0, rise_data);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int r0, f0;
        ack_tie = 1'b1;
        r0 = rdy_rises; f0 = ferr_cycles;
        send_frame(make_frame(8'h07, 1'b1, 1'b1), -1);
        checks++;
        if (rdy_rises - r0 != 1 || rise_data !== 8'h07) begin
            errors++; $display("FAIL parity_good: got rises=%0d data=%h want 1 07",
                               rdy_rises - r0, rise_data);
        end
        checks++;
        if (ferr_cycles != f0) begin
            errors++; $display("FAIL parity_good_ferr: got %0d want 0", ferr_cycles - f0);
        end
        r0 = rdy_rises;
        send_frame(make_frame(8'h07, 1'b0, 1'b1), -1);
        checks++;
        if (ferr_cycles - f0 != 1) begin
            errors++; $display("FAIL parity_bad_ferr: got %0d want 1", ferr_cycles - f0);
        end
        checks++;
        if (rdy_rises != r0) begin
            errors++; $display("FAIL parity_bad_rdy: got %0d rises want 0", rdy_rises - r0);
        end
        $display("test_parity: bad-parity ferr=%0d", ferr_cycles - f0);
    endtask
`endif

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        start_cyc   = 0;
        rise_cyc    = 0;
        rdy_rises   = 0;
        ferr_cycles = 0;
        ovr_cycles  = 0;
        rdy_prev    = 1'b0;
        rise_data   = '0;
        ack_tie     = 1'b0;
        ack_reg     = 1'b0;
        rx          = 1'b1;
        rst         = 1'b0;
        #1;

        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_ack_same_cycle();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
